wb_master_port: RTL and testbench
=================================

Name: wb_master_port

Overview:
- Single-outstanding Wishbone classic-cycle initiator: the bus master counterpart to the team's memory-mapped slaves (output registers, future input registers).
- Accepts one command on a valid/ready request port and runs one Wishbone read or write cycle.
- Retries on rty_i up to a limit, then returns data plus a status code on a valid/ready response port.
- Used by the audio/alarm control sequencer to poke peripherals.

Parameters:
- DATA_WIDTH, 32: data bus width.
- SELECT_WIDTH, 4: byte-select width; DATA_WIDTH/SELECT_WIDTH is the granule size.
- ADDR_WIDTH, 32: address width.
- MAX_RETRY, 3: number of re-issues after rty_i before giving up; 0 means no retries.
- TIMEOUT_CYCLES, 255: cycles in BUS without ack/err/rty before abort; used only with the optional feature.

Ports:
- clk  in  1  bus clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  ADDR_WIDTH  target address.
- req_sel  in  SELECT_WIDTH  byte selects.
- req_dat  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_dat  out  DATA_WIDTH  read data; 0 for writes and for failed cycles.
- rsp_status  out  2  0 OK, 1 BUS_ERR, 2 RETRY_EXHAUSTED, 3 TIMEOUT.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone controls.
- wb_adr_o  out  ADDR_WIDTH  Wishbone address.
- wb_sel_o  out  SELECT_WIDTH  Wishbone selects.
- wb_dat_o  out  DATA_WIDTH  Wishbone write data.
- wb_dat_i  in  DATA_WIDTH  Wishbone read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  Wishbone terminations.

Behaviour:
- Reset value of every output is 0; state = IDLE; retry and timeout counters = 0.
- Reset asserted mid-cycle drops cyc/stb immediately (asynchronously) and discards any pending response.
- States:
  - IDLE: req_ready=1. On accept, register we/adr/sel/dat, clear the retry counter, go to BUS.
  - BUS: cyc=stb=1; bus outputs come from the registered command and are stable for the whole cycle. Termination is sampled on each clk edge:
    - ack_i: capture wb_dat_i if read, status OK, go to RESP.
    - err_i: status BUS_ERR, go to RESP.
    - rty_i with retry count < MAX_RETRY: increment the count, go to BACKOFF.
    - rty_i with retry count = MAX_RETRY: status RETRY_EXHAUSTED, go to RESP.
  - BACKOFF: cyc=stb=0 for exactly one cycle, then back to BUS; the timeout counter is cleared on re-entry to BUS.
  - RESP: rsp_valid=1 and rsp outputs stable until rsp_ready; then go to IDLE. req_ready=0 here, so there is no back-to-back overlap.
- Simultaneous terminations: priority ack > err > rty.
- Latency:
  - Request accept to cyc asserted: 1 cycle.
  - Zero-wait-state slave: ack seen in the first BUS cycle, rsp_valid the next cycle.
  - Minimum accept-to-response: 2 cycles.
  - Minimum command rate: one per 3 cycles when rsp_ready is held high.
- req_ready is a registered/state decode, not combinationally dependent on req_valid.
- Terminations arriving outside BUS are ignored.
- The retry counter is sized $clog2(MAX_RETRY+1), minimum 1 bit.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs while in BUS with no termination.
  - On reaching TIMEOUT_CYCLES it drops cyc/stb, sets status TIMEOUT and goes to RESP.
  - A termination in the same cycle as expiry wins over the timeout.
- Undefined: the master waits in BUS indefinitely; status code 3 is never produced.

Decomposition:
- Package wb_master_pkg holds:
  - typedef enum state_t {IDLE, BUS, BACKOFF, RESP};
  - typedef enum logic [1:0] wb_status_t {WB_OK, WB_BUS_ERR, WB_RETRY_EXHAUSTED, WB_TIMEOUT}.
- One natural sub-module: wb_timeout_counter, with clear/enable/expired and a TIMEOUT_CYCLES parameter; it is instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Write adr=0x4, sel=4'hF, dat=0xA5A5_0001; slave acks in the first cycle.
  - Required: one cyc/stb cycle with we=1; rsp_status=0 and rsp_dat=0 two cycles after accept.
- Read adr=0x0; slave returns 0x1234_5678 after 3 wait states.
  - Required: cyc held 4 cycles with outputs stable; rsp_dat=0x1234_5678, status 0.
- Slave asserts rty twice then ack, with MAX_RETRY=3.
  - Required: three BUS phases separated by single idle cycles; final status 0.
- Slave asserts rty every time, with MAX_RETRY=3.
  - Required: 4 BUS phases, then status 2; req_ready low until the response is consumed.
- Slave asserts err and ack together, then rsp_ready is held low 5 cycles.
  - Required: status 0 (ack priority); rsp outputs stable for the 5 cycles; IDLE one cycle after rsp_ready.
- Reset asserted during BUS with a silent slave; separately, WB_MASTER_TIMEOUT_EN with TIMEOUT_CYCLES=8.
  - Reset case required: cyc/stb drop without waiting for clk, no response issued.
  - Timeout case required: status 3 after 8 BUS cycles.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types for the single-outstanding Wishbone classic-cycle initiator.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        BACKOFF,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        WB_OK,
        WB_BUS_ERR,
        WB_RETRY_EXHAUSTED,
        WB_TIMEOUT
    } wb_status_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts consecutive enabled cycles; expired_c flags the TIMEOUT_CYCLES-th one.
// Instantiated by wb_master_port only when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int unsigned LAST      = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] count_q;

    // Expires during the last permitted cycle so the owner leaves on that edge.
    assign expired_c = enable_i && (count_q == CNT_W'(LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic initiator with retry and status response.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_port
    import wb_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_adr,
    input  logic [SELECT_WIDTH-1:0] req_sel,
    input  logic [DATA_WIDTH-1:0]   req_dat,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int unsigned RETRY_W_RAW = $clog2(MAX_RETRY + 1);
    localparam int unsigned RETRY_W     = (RETRY_W_RAW < 1) ? 1 : RETRY_W_RAW;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   adr;
        logic [SELECT_WIDTH-1:0] sel;
        logic [DATA_WIDTH-1:0]   dat;
    } cmd_t;

    state_t               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    wb_status_t           status_q, status_d;
    logic                 bus_q, bus_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 timeout_c;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != BUS),
        .enable_i  (state_q == BUS),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
    assign timeout_c = 1'b0;
`endif

    // Next state, captured command and response; ack > err > rty > timeout.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        retry_d   = retry_q;
        rsp_dat_d = rsp_dat_q;
        status_d  = status_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d   = '{we: req_we, adr: req_adr, sel: req_sel, dat: req_dat};
                    retry_d = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    rsp_dat_d = cmd_q.we ? '0 : wb_dat_i;
                    status_d  = WB_OK;
                    state_d   = RESP;
                end else if (wb_err_i) begin
                    rsp_dat_d = '0;
                    status_d  = WB_BUS_ERR;
                    state_d   = RESP;
                end else if (wb_rty_i) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = BACKOFF;
                    end else begin
                        rsp_dat_d = '0;
                        status_d  = WB_RETRY_EXHAUSTED;
                        state_d   = RESP;
                    end
                end else if (timeout_c) begin
                    rsp_dat_d = '0;
                    status_d  = WB_TIMEOUT;
                    state_d   = RESP;
                end
            end
            BACKOFF: begin
                state_d = BUS;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_dat_d = '0;
                    status_d  = WB_OK;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Control outputs are registered decodes of the next state.
        bus_d       = (state_d == BUS);
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            retry_q     <= '0;
            rsp_dat_q   <= '0;
            status_q    <= WB_OK;
            bus_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            retry_q     <= retry_d;
            rsp_dat_q   <= rsp_dat_d;
            status_q    <= status_d;
            bus_q       <= bus_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = status_q;
    assign wb_cyc_o   = bus_q;
    assign wb_stb_o   = bus_q;
    assign wb_we_o    = cmd_q.we;
    assign wb_adr_o   = cmd_q.adr;
    assign wb_sel_o   = cmd_q.sel;
    assign wb_dat_o   = cmd_q.dat;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port: writes, waited reads, retry, priority, reset, timeout.
module tb_wb_master_port;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int n_cmp = 0;
    int n_err = 0;

    wb_master_port #(
        .DATA_WIDTH(32), .SELECT_WIDTH(4), .ADDR_WIDTH(32),
        .MAX_RETRY(3), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_sel   = 4'hF;
        req_dat   = dat;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int phases;
        int cyc_cnt;
        logic prev;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
        rsp_ready = 1'b1;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        #12;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_adr", wb_adr_o, 0);
        reset = 1'b0;
        step();
        chk("idle_req_ready", req_ready, 1);

        // Write, zero-wait ack
        issue(1'b1, 32'h4, 32'hA5A5_0001);
        chk("wr_cyc", wb_cyc_o, 1);
        chk("wr_stb", wb_stb_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_adr", wb_adr_o, 32'h4);
        chk("wr_sel", wb_sel_o, 4'hF);
        chk("wr_dat", wb_dat_o, 32'hA5A5_0001);
        chk("wr_req_ready_busy", req_ready, 0);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        chk("wr_cyc_drop", wb_cyc_o, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_status", rsp_status, 0);
        chk("wr_rsp_dat", rsp_dat, 0);
        step();
        chk("wr_rsp_done", rsp_valid, 0);
        chk("wr_back_idle", req_ready, 1);

        // Read with 3 wait states
        issue(1'b0, 32'h0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_cyc", wb_cyc_o, 1);
            chk("rd_wait_adr", wb_adr_o, 0);
            chk("rd_wait_we", wb_we_o, 0);
            step();
        end
        chk("rd_cyc_4th", wb_cyc_o, 1);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        step();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        chk("rd_status", rsp_status, 0);
        step();
        chk("rd_back_idle", req_ready, 1);

        // Two retries then ack
        issue(1'b1, 32'h8, 32'h0000_00AA);
        wb_rty_i = 1'b1;
        step();
        wb_rty_i = 1'b0;
        chk("rty1_backoff", wb_cyc_o, 0);
        step();
        chk("rty1_rebus", wb_cyc_o, 1);
        wb_rty_i = 1'b1;
        step();
        wb_rty_i = 1'b0;
        chk("rty2_backoff", wb_cyc_o, 0);
        step();
        chk("rty2_rebus", wb_cyc_o, 1);
        chk("rty2_adr_stable", wb_adr_o, 32'h8);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        chk("rty_ok_valid", rsp_valid, 1);
        chk("rty_ok_status", rsp_status, 0);
        step();

        // Retry every time: exhaustion after 4 BUS phases
        rsp_ready = 1'b0;
        issue(1'b0, 32'hC, 32'h0);
        wb_rty_i = 1'b1;
        phases = 1;
        prev = wb_cyc_o;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            step();
            if (wb_cyc_o && !prev) phases++;
            prev = wb_cyc_o;
        end
        chk("exh_rsp_valid", rsp_valid, 1);
        chk("exh_phases", phases, 4);
        chk("exh_status", rsp_status, 2);
        chk("exh_rsp_dat", rsp_dat, 0);
        step();
        step();
        chk("exh_req_ready_hold", req_ready, 0);
        chk("exh_valid_hold", rsp_valid, 1);
        wb_rty_i = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("exh_consumed", rsp_valid, 0);
        chk("exh_idle", req_ready, 1);

        // err and ack together, then stall response 5 cycles
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h5555_5555;
        chk("prio_status", rsp_status, 0);
        chk("prio_dat", rsp_dat, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_dat", rsp_dat, 32'hDEAD_BEEF);
            chk("stall_status", rsp_status, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("stall_idle", req_ready, 1);

        // Error alone
        issue(1'b0, 32'h14, 32'h0);
        wb_err_i = 1'b1;
        wb_dat_i = 32'h7777_7777;
        step();
        wb_err_i = 1'b0;
        chk("err_status", rsp_status, 1);
        chk("err_dat", rsp_dat, 0);
        step();

        // Asynchronous reset during BUS with a silent slave
        issue(1'b1, 32'h20, 32'h1);
        chk("rst_bus_cyc", wb_cyc_o, 1);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_cyc_drop", wb_cyc_o, 0);
        chk("async_stb_drop", wb_stb_o, 0);
        chk("async_no_rsp", rsp_valid, 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_no_rsp", rsp_valid, 0);
        chk("post_rst_idle", req_ready, 1);
        chk("post_rst_cyc", wb_cyc_o, 0);

`ifdef WB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'h30, 32'h0);
        cyc_cnt = 1;
        for (int i = 0; i < 30 && !rsp_valid; i++) begin
            step();
            if (wb_cyc_o) cyc_cnt++;
        end
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_bus_cycles", cyc_cnt, 8);
        chk("to_status", rsp_status, 3);
        chk("to_dat", rsp_dat, 0);
        step();
`else
        issue(1'b0, 32'h30, 32'h0);
        cyc_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wb_cyc_o) cyc_cnt++;
        end
        chk("no_to_cyc_held", cyc_cnt, 21);
        chk("no_to_no_rsp", rsp_valid, 0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_F00D;
        step();
        wb_ack_i = 1'b0;
        chk("no_to_late_ack", rsp_dat, 32'h0BAD_F00D);
        chk("no_to_status", rsp_status, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
